instr_fetch_stage: RTL and testbench
====================================

# instr_fetch_stage

Instruction-fetch stage and IF/ID pipeline register. It holds the program counter, drives the byte address into the combinational `instruction_memory`, and captures the returned word together with its PC into the IF/ID register for decode. It also handles stall, flush and branch/jump redirect from later stages, and stops fetching once the PC runs past the end of instruction memory.

## Interface
Parameters:
- `RESET_PC`, default 32'd0: PC value loaded on reset.
- `IMEM_BYTES`, default 32'd32: instruction memory size in bytes (8 words). Must be a multiple of 4.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `read_address`  out  32  current PC; feeds `instruction_memory.read_address`.
- `instr`  in  32  instruction word returned combinationally by memory for `read_address`.
- `stall`  in  1  hold PC and IF/ID contents.
- `flush`  in  1  turn the next IF/ID load into a bubble.
- `redirect_valid`  in  1  branch/jump taken.
- `redirect_target`  in  32  new PC; bits [1:0] are forced to 0.
- `ifid_instr`  out  32  latched instruction.
- `ifid_pc`  out  32  PC of `ifid_instr`.
- `ifid_pc_plus4`  out  32  `ifid_pc + 4`.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `fetch_done`  out  1  high while the FSM is in DONE.
- `fetch_count`  out  32  number of valid instructions loaded into IF/ID since reset.

## Operation
- FSM states: FETCH and DONE. `fetch_done` = (state == DONE).
- PC update priority is reset > redirect > stall > advance.
  - Redirect: `pc <= {redirect_target[31:2], 2'b00}`.
  - Stall: `pc` holds.
  - Advance (FETCH only): `pc <= pc + 4`. Arithmetic is 32-bit and wraps modulo 2^32.
  - DONE with no redirect: `pc` holds.
- State transitions:
  - FETCH → DONE when the FSM advances and `pc + 4 >= IMEM_BYTES`.
  - Any state, on redirect: go to FETCH if the aligned target is below `IMEM_BYTES`, otherwise go to DONE.
  - Stall never changes state.
- IF/ID update priority is reset > (redirect or flush) > stall > load.
  - Redirect or flush: `ifid_valid <= 0`. `ifid_instr`, `ifid_pc` and `ifid_pc_plus4` are cleared to 0, so the squashed wrong-path word is discarded.
  - Stall: all IF/ID fields hold.
  - Load: in FETCH, latch `instr`, `pc` and `pc + 4`, and set `ifid_valid <= 1`.
  - DONE: load a bubble (`ifid_valid <= 0`). `instr` is ignored, since it may be X at out-of-range addresses.
- `fetch_count` increments by 1 on every edge that sets `ifid_valid` through a load. It saturates at 32'hFFFF_FFFF.
- Simultaneous events:
  - Stall and redirect: redirect wins, so the PC moves and IF/ID gets a bubble.
  - Stall and flush: IF/ID gets a bubble and the PC holds.
  - Flush alone: the PC advances normally.

## Timing
- Reset values (one edge with `reset` high): `read_address = RESET_PC`, state = FETCH, all `ifid_*` = 0, `ifid_valid = 0`, `fetch_done = 0`, `fetch_count = 0`.
- Reset asserted mid-operation overrides every other input on that edge.
- Memory path is combinational: `read_address` → `instr` arrives within the same cycle.
- Fetch latency is 1 cycle: the word at PC `p`, presented in cycle n, appears on `ifid_*` after edge n+1.
- Redirect penalty is 1 bubble: the target instruction reaches IF/ID one edge after the redirect edge.
- After the first edge with reset low, the sustained rate is one instruction per cycle with no stalls.
- Outputs are registered and change only on `clk` edges. `fetch_done` rises on the same edge that latches the last in-range word.

## Structure
- Shared package `cpu_pkg` holds:
  - `INSTR_W = 32`, `ADDR_W = 32`, `PC_STEP = 4`.
  - The `fetch_state_t` enum {FETCH, DONE}.
  - The IF/ID bundle struct `ifid_t` {instr, pc, pc_plus4, valid}, so decode can reuse it.
- One natural sub-module: `pc_reg`, which contains the PC register, the priority mux and the alignment masking. The IF/ID register and FSM stay in `instr_fetch_stage`.
- The top level instantiates `instruction_memory` alongside this block. The block does not embed it.

## Test plan
- Reset then free run with the 8-word image and no stall, flush or redirect:
  - `ifid_pc` steps 0, 4, …, 28 on consecutive edges.
  - `ifid_instr` at PC 0 = 32'h0022_1820.
  - `fetch_done` rises with PC 28 latched.
  - `fetch_count = 8`, then `ifid_valid = 0` from that point on.
- `stall` held for 3 cycles while `ifid_pc = 8`: `ifid_pc` stays 8 and `read_address` stays 12 for those 3 cycles, then the sequence resumes at 12.
- `redirect_valid` with target 32'h0000_0013 while PC = 20:
  - One bubble (`ifid_valid = 0`).
  - Then `ifid_pc = 16`; the target is aligned to 16.
  - `fetch_count` is not bumped for the squashed word.
- `stall`, `redirect_valid` (target 4) and `flush` asserted together: the PC becomes 4 and IF/ID gets a bubble; next edge `ifid_pc = 4`.
- In DONE, redirect to 8: state returns to FETCH, then `ifid_pc = 8`. Redirect to 40: the FSM stays in DONE with `read_address = 40` and no valid loads.
- `reset` asserted mid-run at PC 20: after the edge, all outputs are at their reset values, `read_address = 0` and `fetch_count = 0`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch FSM states and the IF/ID bundle.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  // state | meaning
  // FETCH | PC is in range; each unstalled edge loads a word into IF/ID
  // DONE  | PC ran past the end of memory; IF/ID receives bubbles only
  typedef enum logic {
    FETCH = 1'b0,
    DONE  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               valid;
  } ifid_t;

  // Word-align a byte address by clearing its two low bits.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with redirect > hold > advance priority and target alignment.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_target,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_target_aligned
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_target_aligned;

  // Aligned redirect target, also used by the fetch FSM for its range check.
  always_comb begin
    w_target_aligned = word_align(i_target);
  end

  // PC register: reset, then redirect, then advance; otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_redirect) begin
      r_pc <= w_target_aligned;
    end else if (i_advance) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  assign o_pc             = r_pc;
  assign o_target_aligned = w_target_aligned;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM and the IF/ID pipeline register.
module instr_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] IMEM_BYTES = 32'd32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] read_address,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        fetch_done,
  output logic [31:0] fetch_count
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  ifid_t        r_ifid;
  logic [31:0]  r_fetch_count;
  logic [31:0]  w_pc;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_target_aligned;
  logic         w_advance;
  logic         w_load;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk              (clk),
    .reset            (reset),
    .i_redirect       (redirect_valid),
    .i_target         (redirect_target),
    .i_advance        (w_advance),
    .o_pc             (w_pc),
    .o_target_aligned (w_target_aligned)
  );

  assign w_pc_plus4 = w_pc + PC_STEP;

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus the advance/load strobes; a redirect re-evaluates the range.
  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    w_load       = 1'b0;
    if (r_state == FETCH) begin
      w_advance = !stall;
      w_load    = 1'b1;
    end
    if (redirect_valid) begin
      w_state_next = (w_target_aligned < IMEM_BYTES) ? FETCH : DONE;
    end else if (w_advance && (w_pc_plus4 >= IMEM_BYTES)) begin
      w_state_next = DONE;
    end
  end

  // IF/ID register: squash on redirect/flush, hold on stall, else load or bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ifid <= '0;
    end else if (redirect_valid || flush) begin
      r_ifid <= '0;
    end else if (!stall) begin
      if (w_load) begin
        r_ifid.instr    <= instr;
        r_ifid.pc       <= w_pc;
        r_ifid.pc_plus4 <= w_pc_plus4;
        r_ifid.valid    <= 1'b1;
      end else begin
        r_ifid.valid <= 1'b0;
      end
    end
  end

  // Saturating count of real instructions loaded into IF/ID.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count <= '0;
    end else if (!redirect_valid && !flush && !stall && w_load) begin
      if (r_fetch_count != 32'hFFFF_FFFF) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign read_address  = w_pc;
  assign ifid_instr    = r_ifid.instr;
  assign ifid_pc       = r_ifid.pc;
  assign ifid_pc_plus4 = r_ifid.pc_plus4;
  assign ifid_valid    = r_ifid.valid;
  assign fetch_done    = (r_state == DONE);
  assign fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Testbench for instr_fetch_stage: directed vector table plus random traffic
// checked against a behavioural fetch model.
module tb_instr_fetch_stage;

  localparam logic [31:0] IMEM = 32'd32;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect_valid;
  logic [31:0] redirect_target, read_address, instr;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4, fetch_count;
  logic        ifid_valid, fetch_done;

  int total = 0;
  int bad   = 0;

  logic [31:0] img [8];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < IMEM) return img[a[4:2]];
    return 32'hDEAD_BEEF;
  endfunction

  assign instr = mem_word(read_address);

  instr_fetch_stage #(.RESET_PC(32'd0), .IMEM_BYTES(IMEM)) dut (
    .clk             (clk),
    .reset           (reset),
    .read_address    (read_address),
    .instr           (instr),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .ifid_instr      (ifid_instr),
    .ifid_pc         (ifid_pc),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_valid      (ifid_valid),
    .fetch_done      (fetch_done),
    .fetch_count     (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          rst, stl, fls, rv;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    bit          e_v, e_done;
    logic [31:0] e_ra, e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, bit stl, bit fls, bit rv, logic [31:0] tgt,
                              logic [31:0] e_pc, bit e_v, bit e_done,
                              logic [31:0] e_ra, logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.stl = stl; v.fls = fls; v.rv = rv; v.tgt = tgt;
    v.e_pc = e_pc; v.e_v = e_v; v.e_done = e_done; v.e_ra = e_ra; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  // Behavioural model: fetch position, done flag, IF/ID contents and count.
  logic [31:0] m_pc, m_instr, m_ipc, m_ip4, m_cnt;
  bit          m_done, m_v;

  task automatic model_step(input bit rst, input bit stl, input bit fls,
                            input bit rv, input logic [31:0] tgt);
    logic [31:0] t;
    t = tgt - (tgt % 4);
    if (rst) begin
      m_pc = 0; m_done = 0; m_v = 0; m_instr = 0; m_ipc = 0; m_ip4 = 0; m_cnt = 0;
    end else begin
      if (rv || fls) begin
        m_v = 0; m_instr = 0; m_ipc = 0; m_ip4 = 0;
      end else if (!stl) begin
        if (!m_done) begin
          m_v = 1; m_instr = mem_word(m_pc); m_ipc = m_pc; m_ip4 = m_pc + 4;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else begin
          m_v = 0;
        end
      end
      if (rv) begin
        m_pc = t;
        m_done = (t >= IMEM);
      end else if (!stl && !m_done) begin
        m_done = (m_pc + 4 >= IMEM);
        m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic drive(input bit rst, input bit stl, input bit fls,
                       input bit rv, input logic [31:0] tgt);
    reset = rst; stall = stl; flush = fls; redirect_valid = rv; redirect_target = tgt;
  endtask

  initial begin
    img[0] = 32'h0022_1820;
    for (int i = 1; i < 8; i++) img[i] = 32'hA000_0000 | i;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

    // Free run to DONE
    add(1,0,0,0,0,       0,0,0, 0,0);
    for (int k = 1; k <= 8; k++) add(0,0,0,0,0, 4*(k-1),1,(k==8), 4*k,k);
    add(0,0,0,0,0,      28,0,1,32,8);
    // Redirect out of DONE, run to DONE again, then redirect out of range
    add(0,0,0,1,8,       0,0,0, 8,8);
    add(0,0,0,0,0,       8,1,0,12,9);
    for (int j = 3; j <= 7; j++) add(0,0,0,0,0, 4*j,1,(j==7), 4*j+4,7+j);
    add(0,0,0,1,40,      0,0,1,40,14);
    add(0,0,0,0,0,       0,0,1,40,14);
    // Stall, misaligned redirect, combined stall/flush/redirect
    add(1,0,0,0,0,       0,0,0, 0,0);
    for (int k = 1; k <= 3; k++) add(0,0,0,0,0, 4*(k-1),1,0, 4*k,k);
    for (int k = 0; k < 3; k++) add(0,1,0,0,0, 8,1,0,12,3);
    add(0,0,0,0,0,      12,1,0,16,4);
    add(0,0,0,0,0,      16,1,0,20,5);
    add(0,0,0,1,32'h13,  0,0,0,16,5);
    add(0,0,0,0,0,      16,1,0,20,6);
    add(0,1,1,1,4,       0,0,0, 4,6);
    add(0,0,0,0,0,       4,1,0, 8,7);
    add(0,0,0,0,0,       8,1,0,12,8);
    add(0,0,0,0,0,      12,1,0,16,9);
    add(0,0,0,0,0,      16,1,0,20,10);
    // Mid-run reset, flush alone, stall with flush
    add(1,0,0,0,0,       0,0,0, 0,0);
    add(0,0,0,0,0,       0,1,0, 4,1);
    add(0,0,1,0,0,       0,0,0, 8,1);
    add(0,0,0,0,0,       8,1,0,12,2);
    add(0,1,1,0,0,       0,0,0,12,2);
    add(0,0,0,0,0,      12,1,0,16,3);

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].fls, vecs[i].rv, vecs[i].tgt);
      @(posedge clk); #1;
      chk($sformatf("v%0d read_address", i), read_address, vecs[i].e_ra);
      chk($sformatf("v%0d ifid_valid", i), {31'd0, ifid_valid}, {31'd0, vecs[i].e_v});
      chk($sformatf("v%0d fetch_done", i), {31'd0, fetch_done}, {31'd0, vecs[i].e_done});
      chk($sformatf("v%0d fetch_count", i), fetch_count, vecs[i].e_cnt);
      chk($sformatf("v%0d ifid_pc", i), ifid_pc, vecs[i].e_pc);
      if (vecs[i].e_v) begin
        chk($sformatf("v%0d ifid_instr", i), ifid_instr, mem_word(vecs[i].e_pc));
        chk($sformatf("v%0d ifid_pc_plus4", i), ifid_pc_plus4, vecs[i].e_pc + 32'd4);
      end
    end

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      bit          r, s, f, rv;
      logic [31:0] t;
      r  = (n == 0) || ($urandom_range(0, 63) == 0);
      s  = ($urandom_range(0, 4) == 0);
      f  = ($urandom_range(0, 9) == 0);
      rv = ($urandom_range(0, 7) == 0);
      t  = $urandom_range(0, 47);
      drive(r, s, f, rv, t);
      model_step(r, s, f, rv, t);
      @(posedge clk); #1;
      chk("rnd read_address", read_address, m_pc);
      chk("rnd fetch_done", {31'd0, fetch_done}, {31'd0, m_done});
      chk("rnd ifid_valid", {31'd0, ifid_valid}, {31'd0, m_v});
      chk("rnd ifid_pc", ifid_pc, m_ipc);
      chk("rnd ifid_pc_plus4", ifid_pc_plus4, m_ip4);
      chk("rnd ifid_instr", ifid_instr, m_instr);
      chk("rnd fetch_count", fetch_count, m_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
